// File: rtl/ram1p_arbiter.sv
// ----------------------------------------------------------------------------
// ram1p_arbiter
//
// Two-host arbiter in front of a single-port RAM. Each cycle at most one host
// is granted; the granted host's command is forwarded to the RAM in the same
// cycle, and a response (rvalid plus read data for reads) comes back to that
// host exactly one cycle later. When both hosts request in the same cycle,
// a one-bit priority pointer picks the winner. The pointer then moves to the
// loser, so sustained contention alternates between the hosts.
//
// Optional feature (macro RAM1P_ARBITER_END_MON_EN):
//   When defined, a monitor watches granted writes. A write whose byte
//   address (MemBase + word_addr*4) equals EndAddr produces a one-cycle
//   end_valid_o pulse in the following cycle. The same write sets the sticky
//   end_seen_o flag, which stays set until reset. When undefined, both
//   outputs are tied low and no monitor logic is built.
//
// Parameters:
//   AW       word-address width
//   DW       data width (byte mask width is DW/8)
//   MemBase  byte base address of the RAM
//   EndAddr  byte address whose write signals end of simulation
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   hN_req_i              host N access request (held until granted)
//   hN_gnt_o              host N grant (combinational)
//   hN_we_i               host N write enable
//   hN_addr_i             host N word address
//   hN_wdata_i            host N write data
//   hN_wmask_i            host N byte mask
//   hN_rvalid_o           host N response valid, one cycle after grant
//   hN_rdata_o            host N read data (zero unless a read response)
//   ram_req_o             RAM access strobe
//   ram_we_o              RAM write enable
//   ram_addr_o            RAM word address
//   ram_wdata_o           RAM write data
//   ram_wmask_o           RAM byte mask
//   ram_rdata_i           RAM read data, valid one cycle after ram_req_o
//   end_valid_o           end-address write pulse
//   end_seen_o            sticky end-address flag
// ----------------------------------------------------------------------------
module ram1p_arbiter #(
    parameter int          AW      = 14,
    parameter int          DW      = 32,
    parameter logic [31:0] MemBase = 32'h1000_0000,
    parameter logic [31:0] EndAddr = 32'h1000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,

    // Host 0
    input  logic              h0_req_i,
    output logic              h0_gnt_o,
    input  logic              h0_we_i,
    input  logic [AW-1:0]     h0_addr_i,
    input  logic [DW-1:0]     h0_wdata_i,
    input  logic [DW/8-1:0]   h0_wmask_i,
    output logic              h0_rvalid_o,
    output logic [DW-1:0]     h0_rdata_o,

    // Host 1
    input  logic              h1_req_i,
    output logic              h1_gnt_o,
    input  logic              h1_we_i,
    input  logic [AW-1:0]     h1_addr_i,
    input  logic [DW-1:0]     h1_wdata_i,
    input  logic [DW/8-1:0]   h1_wmask_i,
    output logic              h1_rvalid_o,
    output logic [DW-1:0]     h1_rdata_o,

    // RAM side
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [AW-1:0]     ram_addr_o,
    output logic [DW-1:0]     ram_wdata_o,
    output logic [DW/8-1:0]   ram_wmask_o,
    input  logic [DW-1:0]     ram_rdata_i,

    // End-of-simulation monitor
    output logic              end_valid_o,
    output logic              end_seen_o
);

    localparam int MW = DW / 8;

    // ------------------------------------------------------------------------
    // Host-side signals gathered into arrays so the per-host logic can be
    // written once in generate loops.
    // ------------------------------------------------------------------------
    logic [1:0]          req;
    logic [1:0]          we_in;
    logic [AW-1:0]       addr_in  [2];
    logic [DW-1:0]       wdata_in [2];
    logic [MW-1:0]       wmask_in [2];
    logic [1:0]          gnt;
    logic [1:0]          rvalid;
    logic [DW-1:0]       rdata    [2];

    assign req         = {h1_req_i, h0_req_i};
    assign we_in       = {h1_we_i,  h0_we_i};
    assign addr_in[0]  = h0_addr_i;
    assign addr_in[1]  = h1_addr_i;
    assign wdata_in[0] = h0_wdata_i;
    assign wdata_in[1] = h1_wdata_i;
    assign wmask_in[0] = h0_wmask_i;
    assign wmask_in[1] = h1_wmask_i;

    assign h0_gnt_o    = gnt[0];
    assign h1_gnt_o    = gnt[1];
    assign h0_rvalid_o = rvalid[0];
    assign h1_rvalid_o = rvalid[1];
    assign h0_rdata_o  = rdata[0];
    assign h1_rdata_o  = rdata[1];

    // ------------------------------------------------------------------------
    // Arbitration
    // ptr_q names the host that wins the next contended cycle.
    // ------------------------------------------------------------------------
    logic ptr_q;
    logic ptr_d;
    logic gnt_any;
    logic gnt_id;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        // Grants are suppressed while reset is held so nothing reaches the
        // RAM and no response is launched during reset.
        if (!rst_i) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    gnt   = ptr_q ? 2'b10 : 2'b01;
                    // Hand priority to the host that just lost.
                    ptr_d = ~ptr_q;
                end
                default: gnt = 2'b00;
            endcase
        end
    end

    assign gnt_any = gnt[0] | gnt[1];
    assign gnt_id  = gnt[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // ------------------------------------------------------------------------
    // RAM command mux: the granted host drives the RAM; all-zero when idle.
    // ------------------------------------------------------------------------
    always_comb begin
        ram_req_o   = gnt_any;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wmask_o = '0;
        if (gnt_any) begin
            ram_we_o    = we_in[gnt_id];
            ram_addr_o  = addr_in[gnt_id];
            ram_wdata_o = wdata_in[gnt_id];
            ram_wmask_o = wmask_in[gnt_id];
        end
    end

    // ------------------------------------------------------------------------
    // Response pipeline: one stage deep, never stalls. The stage records who
    // was granted and whether it was a write, so the response is steered back
    // to the right host and read data is only exposed for reads.
    // ------------------------------------------------------------------------
    logic rsp_valid_q;
    logic rsp_valid_d;
    logic rsp_id_q;
    logic rsp_id_d;
    logic rsp_we_q;
    logic rsp_we_d;

    always_comb begin
        rsp_valid_d = gnt_any;
        rsp_id_d    = gnt_id;
        rsp_we_d    = ram_we_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_we_q    <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_we_q    <= rsp_we_d;
        end
    end

    // A response that was in flight when reset rises would otherwise show up
    // during the reset cycle; gating with rst_i drops it.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp
            assign rvalid[gi] = rsp_valid_q && (rsp_id_q == 1'(gi)) && !rst_i;
            assign rdata[gi]  = (rvalid[gi] && !rsp_we_q) ? ram_rdata_i : '0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // End-address monitor
    // ------------------------------------------------------------------------
`ifdef RAM1P_ARBITER_END_MON_EN
    logic [31:0] byte_addr;
    logic        end_hit;
    logic        end_valid_q;
    logic        end_valid_d;
    logic        end_seen_q;
    logic        end_seen_d;

    // Byte address of the current RAM command, 32-bit wrap-around.
    assign byte_addr = MemBase + 32'({ram_addr_o, 2'b00});
    assign end_hit   = ram_req_o && ram_we_o && (byte_addr == EndAddr);

    always_comb begin
        end_valid_d = end_hit;
        end_seen_d  = end_seen_q | end_hit;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            end_valid_q <= 1'b0;
            end_seen_q  <= 1'b0;
        end else begin
            end_valid_q <= end_valid_d;
            end_seen_q  <= end_seen_d;
        end
    end

    assign end_valid_o = end_valid_q && !rst_i;
    assign end_seen_o  = end_seen_q;
`else
    assign end_valid_o = 1'b0;
    assign end_seen_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ram1p_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram1p_arbiter
//
// Directed bench for ram1p_arbiter. Inputs change on the falling clock edge;
// combinational outputs are checked 1 time unit later, and registered
// outputs are checked at the next falling edge, after the rising edge that
// loads them. Expected values are written by hand from the intended behaviour.
// ----------------------------------------------------------------------------
module tb_ram1p_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int MW = DW / 8;

`ifdef RAM1P_ARBITER_END_MON_EN
    localparam logic EXP_END = 1'b1;
`else
    localparam logic EXP_END = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            h0_req, h0_gnt, h0_we, h0_rvalid;
    logic [AW-1:0]   h0_addr;
    logic [DW-1:0]   h0_wdata, h0_rdata;
    logic [MW-1:0]   h0_wmask;
    logic            h1_req, h1_gnt, h1_we, h1_rvalid;
    logic [AW-1:0]   h1_addr;
    logic [DW-1:0]   h1_wdata, h1_rdata;
    logic [MW-1:0]   h1_wmask;
    logic            ram_req, ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata, ram_rdata;
    logic [MW-1:0]   ram_wmask;
    logic            end_valid, end_seen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram1p_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .MemBase (32'h1000_0000),
        .EndAddr (32'h1000_0000)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .h0_req_i    (h0_req),
        .h0_gnt_o    (h0_gnt),
        .h0_we_i     (h0_we),
        .h0_addr_i   (h0_addr),
        .h0_wdata_i  (h0_wdata),
        .h0_wmask_i  (h0_wmask),
        .h0_rvalid_o (h0_rvalid),
        .h0_rdata_o  (h0_rdata),
        .h1_req_i    (h1_req),
        .h1_gnt_o    (h1_gnt),
        .h1_we_i     (h1_we),
        .h1_addr_i   (h1_addr),
        .h1_wdata_i  (h1_wdata),
        .h1_wmask_i  (h1_wmask),
        .h1_rvalid_o (h1_rvalid),
        .h1_rdata_o  (h1_rdata),
        .ram_req_o   (ram_req),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_wmask_o (ram_wmask),
        .ram_rdata_i (ram_rdata),
        .end_valid_o (end_valid),
        .end_seen_o  (end_seen)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        h0_req = 0; h0_we = 0; h0_addr = '0; h0_wdata = '0; h0_wmask = '0;
        h1_req = 0; h1_we = 0; h1_addr = '0; h1_wdata = '0; h1_wmask = '0;
        ram_rdata = '0;

        // ---- Reset: requests present but nothing may be granted ----
        @(negedge clk);
        h0_req = 1; h1_req = 1;
        #1;
        chk("rst_h0_gnt", h0_gnt, 0);
        chk("rst_h1_gnt", h1_gnt, 0);
        chk("rst_ram_req", ram_req, 0);
        @(negedge clk);
        #1;
        chk("rst_h0_rvalid", h0_rvalid, 0);
        chk("rst_h1_rvalid", h1_rvalid, 0);
        chk("rst_end_valid", end_valid, 0);
        chk("rst_end_seen", end_seen, 0);
        $display("reset: done");

        // ---- Single h0 read of 0x10 ----
        @(negedge clk);
        rst = 0; h1_req = 0;
        h0_req = 1; h0_we = 0; h0_addr = 14'h10;
        #1;
        chk("rd_h0_gnt", h0_gnt, 1);
        chk("rd_h1_gnt", h1_gnt, 0);
        chk("rd_ram_req", ram_req, 1);
        chk("rd_ram_we", ram_we, 0);
        chk("rd_ram_addr", ram_addr, 14'h10);
        @(negedge clk);
        h0_req = 0; ram_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rd_h0_rvalid", h0_rvalid, 1);
        chk("rd_h0_rdata", h0_rdata, 32'hDEAD_BEEF);
        chk("rd_h1_rvalid", h1_rvalid, 0);
        chk("rd_h1_rdata", h1_rdata, 0);
        chk("idle_ram_req", ram_req, 0);
        chk("idle_ram_addr", ram_addr, 0);
        $display("single read h0 addr=0x10: rdata=%h", h0_rdata);

        // ---- Continuous contention: h0 reads 0x20, h1 writes 0x30 ----
        ram_rdata = 32'hA5A5_A5A5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            h0_req = 1; h0_we = 0; h0_addr = 14'h20;
            h1_req = 1; h1_we = 1; h1_addr = 14'h30;
            h1_wdata = 32'h1234_5678; h1_wmask = 4'hA;
            #1;
            chk("cont_h0_gnt", h0_gnt, (i % 2 == 0));
            chk("cont_h1_gnt", h1_gnt, (i % 2 == 1));
            chk("cont_ram_we", ram_we, (i % 2 == 1));
            chk("cont_ram_addr", ram_addr, (i % 2 == 0) ? 14'h20 : 14'h30);
            chk("cont_ram_wdata", ram_wdata, (i % 2 == 0) ? 32'h0 : 32'h1234_5678);
            chk("cont_ram_wmask", ram_wmask, (i % 2 == 0) ? 4'h0 : 4'hA);
            if (i > 0) begin
                chk("cont_h0_rvalid", h0_rvalid, ((i - 1) % 2 == 0));
                chk("cont_h1_rvalid", h1_rvalid, ((i - 1) % 2 == 1));
                chk("cont_h0_rdata", h0_rdata, ((i - 1) % 2 == 0) ? 32'hA5A5_A5A5 : 32'h0);
                chk("cont_h1_rdata", h1_rdata, 0);
            end
            $display("contention cycle %0d: gnt h0=%0b h1=%0b", i, h0_gnt, h1_gnt);
        end
        @(negedge clk);
        h0_req = 0; h1_req = 0;
        #1;
        chk("cont_last_h1_rvalid", h1_rvalid, 1);
        chk("cont_last_h0_rvalid", h0_rvalid, 0);
        chk("cont_last_h1_rdata", h1_rdata, 0);
        chk("cont_idle_wdata", ram_wdata, 0);

        // ---- h1 alone x3, then contention: pointer still 0 ----
        h1_we = 0; h1_addr = 14'h7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            h1_req = 1;
            #1;
            chk("solo_h1_gnt", h1_gnt, 1);
            chk("solo_h0_gnt", h0_gnt, 0);
            $display("h1 solo cycle %0d: gnt h1=%0b", i, h1_gnt);
        end
        @(negedge clk);
        h0_req = 1; h1_req = 1;
        #1;
        chk("after_solo_h0_gnt", h0_gnt, 1);
        chk("after_solo_h1_gnt", h1_gnt, 0);
        chk("after_solo_h1_rvalid", h1_rvalid, 1);
        @(negedge clk);
        #1;
        chk("after_solo2_h1_gnt", h1_gnt, 1);
        chk("after_solo2_h0_rvalid", h0_rvalid, 1);
        $display("contention after h1 solo: second grant h1=%0b", h1_gnt);

        // ---- Reset right after an h0 grant (pointer moved to 1) ----
        @(negedge clk);
        #1;
        chk("pre_rst_h0_gnt", h0_gnt, 1);
        @(negedge clk);
        rst = 1; h0_req = 0; h1_req = 0;
        #1;
        chk("rst_drop_h0_rvalid", h0_rvalid, 0);
        @(negedge clk);
        rst = 0; h0_req = 1; h1_req = 1;
        #1;
        chk("post_rst_h0_rvalid", h0_rvalid, 0);
        chk("post_rst_h0_gnt", h0_gnt, 1);
        chk("post_rst_h1_gnt", h1_gnt, 0);
        $display("reset after grant: pointer back to h0 gnt=%0b", h0_gnt);
        @(negedge clk);
        h0_req = 0; h1_req = 0;

        // ---- End-address write from h1, then a read of the same address ----
        @(negedge clk);
        h1_req = 1; h1_we = 1; h1_addr = 14'h0; h1_wdata = 32'h0000_CAFE; h1_wmask = 4'hF;
        #1;
        chk("end_h1_gnt", h1_gnt, 1);
        @(negedge clk);
        h1_req = 0;
        #1;
        chk("end_valid_pulse", end_valid, EXP_END);
        chk("end_seen_set", end_seen, EXP_END);
        chk("end_h1_rvalid", h1_rvalid, 1);
        @(negedge clk);
        h1_req = 1; h1_we = 0;
        #1;
        chk("end_valid_once", end_valid, 0);
        chk("end_seen_sticky", end_seen, EXP_END);
        @(negedge clk);
        h1_req = 0;
        #1;
        chk("end_read_no_pulse", end_valid, 0);
        chk("end_seen_after_read", end_seen, EXP_END);
        $display("end monitor: end_seen=%0b", end_seen);
        @(negedge clk);
        rst = 1;
        #1;
        chk("end_rst_valid", end_valid, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("end_rst_seen", end_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram1p_arbiter.md
RAM1P_ARBITER -- requirements
Module: ram1p_arbiter

Interface
REQ-001 SHALL have parameter AW, default 14, meaning word-address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width; byte mask width is DW/8.
REQ-003 SHALL have parameter MemBase, default 32'h1000_0000, meaning byte base address of the RAM.
REQ-004 SHALL have parameter EndAddr, default 32'h1000_0000, meaning byte address whose write signals end of simulation.
REQ-005 SHALL have ports clk_i (input, 1, sole clock) and rst_i (input, 1); one clock, reset is synchronous and active-high.
REQ-006 SHALL have, for n in {0,1}: hn_req_i in 1, access request; hn_gnt_o out 1, grant; hn_we_i in 1, write enable; hn_addr_i in AW, word address; hn_wdata_i in DW, write data; hn_wmask_i in DW/8, byte mask; hn_rvalid_o out 1, response valid; hn_rdata_o out DW, read data.
REQ-007 SHALL have RAM-side ports: ram_req_o out 1; ram_we_o out 1; ram_addr_o out AW; ram_wdata_o out DW; ram_wmask_o out DW/8; ram_rdata_i in DW, valid one cycle after ram_req_o.
REQ-008 SHALL have end_valid_o out 1, end-address write pulse, and end_seen_o out 1, sticky end flag.

Function
REQ-009 SHALL grant at most one requester per cycle; hn_gnt_o is combinational from the hn_req_i signals and the priority pointer.
REQ-010 SHALL grant the sole requester when only one of h0_req_i/h1_req_i is high.
REQ-011 SHALL, when both request, grant the port named by the priority pointer (0 = h0, 1 = h1).
REQ-012 SHALL set the pointer to the non-granted port after every cycle in which both requested; otherwise the pointer holds.
REQ-013 SHALL drive ram_req_o = h0_gnt_o | h1_gnt_o, and SHALL mux we/addr/wdata/wmask from the granted port in the same cycle.
REQ-014 SHALL drive all ram_* data outputs to zero when there is no grant.
REQ-015 SHALL register the granted port id and a valid bit, giving hn_rvalid_o exactly one cycle after hn_gnt_o for both reads and writes.
REQ-016 SHALL drive hn_rdata_o = ram_rdata_i when hn_rvalid_o is high for a read, and zero otherwise.
REQ-017 SHALL support back-to-back grants every cycle; the response pipeline is one deep and never stalls.
REQ-018 A requester SHALL hold req and the payload until granted; the block SHALL NOT check this.
REQ-019 SHALL compute the byte address as MemBase + {addr, 2'b00}, 32-bit wrap-around arithmetic.

Reset
REQ-020 On rst_i: pointer = 0, response-valid = 0, end_seen_o = 0. The reset takes effect at the next clk_i edge.
REQ-021 During rst_i high, hn_gnt_o, ram_req_o, hn_rvalid_o and end_valid_o SHALL be 0.
REQ-022 A response pending when reset asserts SHALL be dropped; no rvalid is issued after reset.

Configuration
REQ-023 Macro RAM1P_ARBITER_END_MON_EN defined: end_valid_o pulses one cycle after a granted write whose byte address equals EndAddr, and end_seen_o sets on that pulse and stays set until reset.
REQ-024 Macro RAM1P_ARBITER_END_MON_EN undefined: end_valid_o and end_seen_o are tied to 0, no monitor logic is present, and the ports remain.

Verification
REQ-025 h0 read at addr 0x10 alone, RAM returns 0xDEADBEEF -> h0_gnt_o in the same cycle, h0_rvalid_o next cycle with rdata 0xDEADBEEF, h1 outputs 0.
REQ-026 h0 and h1 request continuously for 4 cycles from reset -> grants h0,h1,h0,h1; each rvalid follows its grant by exactly one cycle.
REQ-027 h1 alone for 3 cycles, then both request -> h1 gets 3 grants; the pointer stays 0, so the first contended grant goes to h0.
REQ-028 rst_i asserted in the cycle after an h0 grant -> no h0_rvalid_o, and after release the pointer is 0.
REQ-029 With END_MON_EN, defaults, h1 write to addr 0 -> end_valid_o pulses once, end_seen_o stays 1; a read of addr 0 -> no pulse.
REQ-030 Without END_MON_EN, the same write -> end_valid_o and end_seen_o remain 0.
